mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between `exe_stage` and `wb_stage`.
- Accepts the 104-bit execute bus and waits for the data-SRAM response of any request issued upstream.
- Formats load data and forwards hazard/bypass information back to decode.
- Drives the ms→ws bus.
- Tracks in-flight SRAM transactions across pipeline flushes so stale responses are discarded and never delivered to a younger instruction.

## Interface
Parameters: none (widths come from `mycpu.h`: `ES_TO_MS_BUS_WD`=104, `MS_TO_WS_BUS_WD`=94, `STALL_BUS_WD`=10, `FORWARD_BUS_WD`=33).
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  exception/eret flush from writeback
- ws_allowin  in  1  writeback can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  execute bus valid
- es_to_ms_bus  in  104  {bd, exc, exc_type[7:0], eret_flush, cp0_wen, res_from_cp0, cp0_addr[7:0], res_from_mem, inst_load[6:0], ld_extd_op[4:0], gr_we, dest[4:0], alu_result[31:0], pc[31:0]}
- es_mem_req  in  1  execute issued a data-SRAM request this cycle (equal to its `data_sram_req`)
- data_sram_data_ok  in  1  in-order response strobe (loads and stores)
- data_sram_rdata  in  32  response data
- ms_to_ws_valid  out  1
- ms_to_ws_bus  out  94  {bd, exc, exc_type[7:0], eret_flush, cp0_wen, res_from_cp0, cp0_addr[7:0], rf_wen[3:0], dest[4:0], final_result[31:0], pc[31:0]}
- stall_ms_bus  out  10  {{5{ms_valid & gr_we}}, dest}
- forward_ms_bus  out  33  {ms_valid & ms_ready_go & !res_from_cp0, final_result}
- ms_exc_eret  out  1  ms_valid & (exc | eret_flush), to execute's exception/eret input

## Operation
- Pipeline handshake:
  - `ms_allowin = !ms_valid | (ms_ready_go & ws_allowin)`.
  - `ms_to_ws_valid = ms_valid & ms_ready_go`.
  - The bus register loads on `es_to_ms_valid & ms_allowin`.
- Wait flag `ms_wait` is set on accept when `es_mem_req` is high. It is set even for excepting entries: upstream issues a harmless zero-strobe request for these, and its response must still be consumed.
- Cancel counter `cancel_cnt` (2 bits, max 2) counts responses owed to flushed instructions.
- On each `data_ok`:
  - If `cancel_cnt != 0`, decrement and drop the response.
  - Else, if `ms_wait` is set, the response belongs to the current entry: clear `ms_wait` and capture `rdata` into `rdata_buf`.
- `ms_ready_go = !ms_wait | (data_ok & cancel_cnt==0)`.
- Load data source: live `rdata` in the arrival cycle, otherwise `rdata_buf`.
- Load formatting is by `inst_load` one-hot {lw, lb, lbu, lh, lhu, lwl, lwr} and `alu_result[1:0]`:
  - lb/lbu/lh/lhu select the byte/halfword and sign- or zero-extend; lw passes through.
  - lwl/lwr shift the bytes into position and set `rf_wen` to the bytes written; writeback merges them.
  - Non-loads: `rf_wen = {4{gr_we}}`, `final_result = alu_result`.
  - `ld_extd_op` is reserved and ignored.
- Flush:
  - `ms_valid <= 0`.
  - `cancel_cnt <= cancel_cnt − (drop this cycle) + (ms_valid & ms_wait & !data_ok_consumed_now) + (es_to_ms_valid & ms_allowin & es_mem_req)`.
  - `ms_wait <= 0`.
- Reset clears `ms_valid`, `ms_wait` and `cancel_cnt`. Reset mid-transaction abandons outstanding responses (memory is reset too).

## Timing
- Reset values: `ms_to_ws_valid` 0, `stall_ms_bus` valid bits 0, `forward_ms_bus[32]` 0, `ms_exc_eret` 0, `ms_allowin` 1.
- Non-memory instruction: one cycle in stage.
- Load with `data_ok` in the cycle after accept: one cycle; the result is combinational from `rdata`.
- Late response: the stage holds until `data_ok`. If writeback is stalled when `data_ok` arrives, the data is held in `rdata_buf` and `ms_ready_go` stays 1.
- A new entry may be accepted while `cancel_cnt != 0`. Its response is recognised only after the counter reaches 0.
- `data_ok` arriving with `ms_wait==0` and `cancel_cnt==0` is a protocol error: it is ignored, and a simulation assertion fires.

## Structure
- Bus widths and field offsets live in the shared `mycpu.h`.
- One combinational sub-module, `ld_select` (inputs: inst_load, addr[1:0], rdata; outputs: result[31:0], rf_wen[3:0]).
- The counter, wait flag and buffer stay in `mem_stage`.

## Test plan
- lw at addr 0x100, `data_ok`+`rdata`=0x8899AABB one cycle after accept → `ms_to_ws_valid` same cycle, `final_result`=0x8899AABB, `rf_wen`=4'hF.
- lb addr[1:0]=2, `rdata`=0x11F2_3344, `ws_allowin` low 3 cycles → `final_result`=0xFFFFFFF2 held stable; single retire when `ws_allowin` rises.
- lwl addr[1:0]=1, `rdata`=0xAABBCCDD → `final_result`=0xCCDD0000, `rf_wen`=4'b1100; lwr addr[1:0]=1 → 0x00AABBCC, `rf_wen`=4'b0111.
- Load waiting, flush asserted together with a new `es_mem_req` accept → `cancel_cnt`=2; next two `data_ok` dropped; third `data_ok` completes the post-flush load.
- add with `gr_we`, dest=7 → `stall_ms_bus`=10'b11111_00111, forward valid 1 with `alu_result`; an mfc0 → forward valid 0.
- Entry with exc=1 and `es_mem_req` → `ms_exc_eret`=1; the stage waits for `data_ok` before `ms_to_ws_valid`.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and load-decode helpers for the memory stage.
// Purely declarative: no logic, no latency.
// Field order in the structs is MSB first and must match the packed bus order.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 104;
    localparam int MS_TO_WS_BUS_WD = 94;
    localparam int STALL_BUS_WD    = 10;
    localparam int FORWARD_BUS_WD  = 33;

    // Bit positions inside the one-hot inst_load field.
    localparam int LD_LW_BIT  = 6;
    localparam int LD_LB_BIT  = 5;
    localparam int LD_LBU_BIT = 4;
    localparam int LD_LH_BIT  = 3;
    localparam int LD_LHU_BIT = 2;
    localparam int LD_LWL_BIT = 1;
    localparam int LD_LWR_BIT = 0;

    typedef struct packed {
        logic        bd;
        logic        exc;
        logic [7:0]  exc_type;
        logic        eret_flush;
        logic        cp0_wen;
        logic        res_from_cp0;
        logic [7:0]  cp0_addr;
        logic        res_from_mem;
        logic [6:0]  inst_load;
        logic [4:0]  ld_extd_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        bd;
        logic        exc;
        logic [7:0]  exc_type;
        logic        eret_flush;
        logic        cp0_wen;
        logic        res_from_cp0;
        logic [7:0]  cp0_addr;
        logic [3:0]  rf_wen;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_W,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU,
        LD_WL,
        LD_WR
    } ld_kind_t;

    // Collapse the one-hot load field into a kind; an all-zero field means no load.
    function automatic ld_kind_t ld_kind(input logic [6:0] inst_load);
        ld_kind_t k;
        k = LD_NONE;
        if (inst_load[LD_LW_BIT])       k = LD_W;
        else if (inst_load[LD_LB_BIT])  k = LD_B;
        else if (inst_load[LD_LBU_BIT]) k = LD_BU;
        else if (inst_load[LD_LH_BIT])  k = LD_H;
        else if (inst_load[LD_LHU_BIT]) k = LD_HU;
        else if (inst_load[LD_LWL_BIT]) k = LD_WL;
        else if (inst_load[LD_LWR_BIT]) k = LD_WR;
        return k;
    endfunction

endpackage

// File: rtl/mem_stage_ld.sv
// Load-data formatter: byte/half select with extension, lwl/lwr byte placement.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever its inputs are.
module ld_select
    import mem_stage_pkg::*;
(
    input  logic [6:0]  inst_load,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result,
    output logic [3:0]  rf_wen
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the word.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend or place the selected data; lwl/lwr only enable the bytes they own.
    always_comb begin
        result = rdata;
        rf_wen = 4'hF;
        case (ld_kind(inst_load))
            LD_B:  result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU: result = {24'd0, byte_sel};
            LD_H:  result = {{16{half_sel[15]}}, half_sel};
            LD_HU: result = {16'd0, half_sel};
            LD_WL: begin
                // Low-addressed bytes of the word move up to the register's top.
                result = rdata << {~addr, 3'b000};
                rf_wen = 4'b1111 << ~addr;
            end
            LD_WR: begin
                // High-addressed bytes of the word move down to the register's bottom.
                result = rdata >> {addr, 3'b000};
                rf_wen = 4'b1111 >> addr;
            end
            default: begin
                result = rdata;
                rf_wen = 4'hF;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: holds one execute entry, waits for its SRAM response, formats load data.
// Latency: one cycle for non-memory ops and next-cycle responses; otherwise until data_ok.
// Backpressure: ms_allowin drops while waiting or while writeback stalls; data is buffered.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_mem_req,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
    output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus,
    output logic                       ms_exc_eret
);

    es_to_ms_t   ms_entry;
    ms_to_ws_t   ws_out;
    logic        ms_valid;
    logic        ms_wait;
    logic [1:0]  cancel_cnt;
    logic [1:0]  cancel_nxt;
    logic [31:0] rdata_buf;

    logic        ms_ready_go;
    logic        accept;
    logic        resp_drop;
    logic        resp_take;
    logic [31:0] ld_rdata;
    logic [31:0] ld_result;
    logic [3:0]  ld_wen;
    logic [31:0] final_result;
    logic [3:0]  rf_wen;
    logic        ld_extd_unused;

    // Responses arrive in order: any owed to flushed work come first and are dropped.
    assign resp_drop   = data_sram_data_ok & (cancel_cnt != 2'd0);
    assign resp_take   = data_sram_data_ok & (cancel_cnt == 2'd0) & ms_wait;

    assign ms_ready_go = !ms_wait | (data_sram_data_ok & (cancel_cnt == 2'd0));
    assign ms_allowin  = !ms_valid | (ms_ready_go & ws_allowin);
    assign accept      = es_to_ms_valid & ms_allowin;

    // Entry register: captured on every accept, flushed or not.
    always_ff @(posedge clk) begin
        if (accept) begin
            ms_entry <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    // Stage occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Wait flag: set for any entry that has a request in flight, excepting entries included.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_wait <= 1'b0;
        end else if (flush) begin
            ms_wait <= 1'b0;
        end else if (accept) begin
            ms_wait <= es_mem_req;
        end else if (resp_take) begin
            ms_wait <= 1'b0;
        end
    end

    // Owed-response count: a flush hands the current and incoming requests over to it.
    always_comb begin
        cancel_nxt = cancel_cnt;
        if (resp_drop) begin
            cancel_nxt = cancel_nxt - 2'd1;
        end
        if (flush) begin
            if (ms_valid & ms_wait & !resp_take) begin
                cancel_nxt = cancel_nxt + 2'd1;
            end
            if (accept & es_mem_req) begin
                cancel_nxt = cancel_nxt + 2'd1;
            end
        end
    end

    // Counter register; reset abandons anything outstanding since memory resets too.
    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_cnt <= 2'd0;
        end else begin
            cancel_cnt <= cancel_nxt;
        end
    end

    // Hold the response so the result stays stable while writeback is stalled.
    always_ff @(posedge clk) begin
        if (resp_take) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    assign ld_rdata = resp_take ? data_sram_rdata : rdata_buf;

    ld_select u_ld_select (
        .inst_load (ms_entry.inst_load),
        .addr      (ms_entry.alu_result[1:0]),
        .rdata     (ld_rdata),
        .result    (ld_result),
        .rf_wen    (ld_wen)
    );

    // Loads take formatted memory data; everything else forwards the ALU result.
    always_comb begin
        final_result = ms_entry.alu_result;
        rf_wen       = {4{ms_entry.gr_we}};
        if (ms_entry.res_from_mem) begin
            final_result = ld_result;
            rf_wen       = ld_wen & {4{ms_entry.gr_we}};
        end
    end

    // Assemble the writeback bus from the held entry and the formatted result.
    always_comb begin
        ws_out              = '0;
        ws_out.bd           = ms_entry.bd;
        ws_out.exc          = ms_entry.exc;
        ws_out.exc_type     = ms_entry.exc_type;
        ws_out.eret_flush   = ms_entry.eret_flush;
        ws_out.cp0_wen      = ms_entry.cp0_wen;
        ws_out.res_from_cp0 = ms_entry.res_from_cp0;
        ws_out.cp0_addr     = ms_entry.cp0_addr;
        ws_out.rf_wen       = rf_wen;
        ws_out.dest         = ms_entry.dest;
        ws_out.final_result = final_result;
        ws_out.pc           = ms_entry.pc;
    end

    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign ms_to_ws_bus   = ws_out;
    assign stall_ms_bus   = {{5{ms_valid & ms_entry.gr_we}}, ms_entry.dest};
    assign forward_ms_bus = {ms_valid & ms_ready_go & !ms_entry.res_from_cp0, final_result};
    assign ms_exc_eret    = ms_valid & (ms_entry.exc | ms_entry.eret_flush);

    // Extended-load opcode is carried on the bus but has no meaning here.
    assign ld_extd_unused = ^ms_entry.ld_extd_op;

    // A response with nothing outstanding means the memory side broke protocol.
    spurious_data_ok: assert property (@(posedge clk) disable iff (reset)
        !(data_sram_data_ok && (cancel_cnt == 2'd0) && !ms_wait));

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load formatting, stalls, flush cancellation, hazards.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Finishes after a fixed sequence with a one-line summary.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [103:0] es_to_ms_bus;
    logic         es_mem_req;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ms_to_ws_valid;
    logic [93:0]  ms_to_ws_bus;
    logic [9:0]   stall_ms_bus;
    logic [32:0]  forward_ms_bus;
    logic         ms_exc_eret;

    localparam logic [6:0] LW  = 7'b1000000;
    localparam logic [6:0] LB  = 7'b0100000;
    localparam logic [6:0] LBU = 7'b0010000;
    localparam logic [6:0] LH  = 7'b0001000;
    localparam logic [6:0] LHU = 7'b0000100;
    localparam logic [6:0] LWL = 7'b0000010;
    localparam logic [6:0] LWR = 7'b0000001;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_mem_req        (es_mem_req),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .stall_ms_bus      (stall_ms_bus),
        .forward_ms_bus    (forward_ms_bus),
        .ms_exc_eret       (ms_exc_eret)
    );

    // Execute bus: bd mirrors pc[3], exc_type/cp0_addr are fixed tags, ld_extd_op nonzero junk.
    function automatic logic [103:0] mk_es(input logic exc, input logic eret, input logic cp0r,
                                           input logic mem, input logic [6:0] ld, input logic we,
                                           input logic [4:0] dest, input logic [31:0] alu,
                                           input logic [31:0] pc);
        logic [7:0] et;
        logic [7:0] ca;
        et = exc ? 8'h04 : 8'h00;
        ca = cp0r ? 8'h60 : 8'h00;
        return {pc[3], exc, et, eret, 1'b0, cp0r, ca, mem, ld, 5'b10101, we, dest, alu, pc};
    endfunction

    // Expected writeback bus for an entry built by mk_es.
    function automatic logic [93:0] mk_ms(input logic exc, input logic eret, input logic cp0r,
                                          input logic [3:0] wen, input logic [4:0] dest,
                                          input logic [31:0] res, input logic [31:0] pc);
        logic [7:0] et;
        logic [7:0] ca;
        et = exc ? 8'h04 : 8'h00;
        ca = cp0r ? 8'h60 : 8'h00;
        return {pc[3], exc, et, eret, 1'b0, cp0r, ca, wen, dest, res, pc};
    endfunction

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Accept one load, answer it the next cycle, check the retiring bus.
    task automatic do_load(input string tag, input logic [6:0] ld, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp_res,
                           input logic [3:0] exp_wen, input logic [31:0] pc);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b0, 1'b0, 1'b0, 1'b1, ld, 1'b1, 5'd3, addr, pc);
        es_mem_req     = 1'b1;
        @(negedge clk);
        check_vec({tag, "/allowin"}, 128'(ms_allowin), 128'd1);
        next_cyc();
        es_to_ms_valid    = 1'b0;
        es_mem_req        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        @(negedge clk);
        check_vec({tag, "/valid"}, 128'(ms_to_ws_valid), 128'd1);
        check_vec({tag, "/bus"}, 128'(ms_to_ws_bus),
                  128'(mk_ms(1'b0, 1'b0, 1'b0, exp_wen, 5'd3, exp_res, pc)));
        next_cyc();
        data_sram_data_ok = 1'b0;
    endtask

    logic [6:0]  t_ld   [9] = '{LW, LWL, LWR, LBU, LH, LHU, LWL, LWR, LB};
    logic [31:0] t_addr [9] = '{32'h100, 32'h301, 32'h301, 32'h203, 32'h200,
                                32'h202, 32'h303, 32'h302, 32'h201};
    logic [31:0] t_rd   [9] = '{32'h8899AABB, 32'hAABBCCDD, 32'hAABBCCDD, 32'h9A000000,
                                32'h12348765, 32'h80011234, 32'hAABBCCDD, 32'hAABBCCDD,
                                32'h11F23344};
    logic [31:0] t_res  [9] = '{32'h8899AABB, 32'hCCDD0000, 32'h00AABBCC, 32'h0000009A,
                                32'hFFFF8765, 32'h00008001, 32'hAABBCCDD, 32'h0000AABB,
                                32'h00000033};
    logic [3:0]  t_wen  [9] = '{4'hF, 4'b1100, 4'b0111, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0011, 4'hF};

    initial begin
        reset             = 1'b1;
        flush             = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        es_mem_req        = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check_vec("rst/valid", 128'(ms_to_ws_valid), 128'd0);
        check_vec("rst/stall_v", 128'(stall_ms_bus[9:5]), 128'd0);
        check_vec("rst/fwd_v", 128'(forward_ms_bus[32]), 128'd0);
        check_vec("rst/exc_eret", 128'(ms_exc_eret), 128'd0);
        check_vec("rst/allowin", 128'(ms_allowin), 128'd1);
        next_cyc();

        // Load formatting table, each answered the cycle after accept.
        for (int i = 0; i < 9; i++) begin
            do_load($sformatf("ld%0d", i), t_ld[i], t_addr[i], t_rd[i], t_res[i], t_wen[i],
                    32'hBFC0_1000 + 32'(i) * 32'd8);
        end

        // lb answered while writeback stalls for three cycles: result held from the buffer.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b0, 1'b0, 1'b0, 1'b1, LB, 1'b1, 5'd4, 32'h202, 32'hBFC0_0200);
        es_mem_req     = 1'b1;
        next_cyc();
        es_to_ms_valid    = 1'b0;
        es_mem_req        = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11F2_3344;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_vec($sformatf("lbstall%0d/valid", c), 128'(ms_to_ws_valid), 128'd1);
            check_vec($sformatf("lbstall%0d/res", c), 128'(ms_to_ws_bus[63:32]),
                      128'h FFFF_FFF2);
            check_vec($sformatf("lbstall%0d/allowin", c), 128'(ms_allowin), 128'd0);
            next_cyc();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'hDEAD_BEEF;
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        check_vec("lbstall/release_res", 128'(ms_to_ws_bus[63:32]), 128'hFFFF_FFF2);
        check_vec("lbstall/release_allowin", 128'(ms_allowin), 128'd1);
        next_cyc();
        @(negedge clk);
        check_vec("lbstall/retired_once", 128'(ms_to_ws_valid), 128'd0);
        next_cyc();

        // add, then mfc0 back to back, then a store that waits one extra cycle.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 5'd7, 32'h1234_5678,
                               32'hBFC0_0300);
        es_mem_req     = 1'b0;
        next_cyc();
        es_to_ms_bus   = mk_es(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 5'd9, 32'h0000_0060,
                               32'hBFC0_0308);
        @(negedge clk);
        check_vec("add/stall", 128'(stall_ms_bus), 128'(10'b11111_00111));
        check_vec("add/fwd", 128'(forward_ms_bus), 128'({1'b1, 32'h1234_5678}));
        check_vec("add/bus", 128'(ms_to_ws_bus),
                  128'(mk_ms(1'b0, 1'b0, 1'b0, 4'hF, 5'd7, 32'h1234_5678, 32'hBFC0_0300)));
        next_cyc();
        es_to_ms_bus   = mk_es(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 5'd2, 32'h0000_0500,
                               32'hBFC0_0310);
        es_mem_req     = 1'b1;
        @(negedge clk);
        check_vec("mfc0/fwd_v", 128'(forward_ms_bus[32]), 128'd0);
        check_vec("mfc0/stall", 128'(stall_ms_bus), 128'(10'b11111_01001));
        check_vec("mfc0/valid", 128'(ms_to_ws_valid), 128'd1);
        next_cyc();
        es_to_ms_valid = 1'b0;
        es_mem_req     = 1'b0;
        @(negedge clk);
        check_vec("sw/stall", 128'(stall_ms_bus), 128'(10'b00000_00010));
        check_vec("sw/wait_valid", 128'(ms_to_ws_valid), 128'd0);
        check_vec("sw/wait_allowin", 128'(ms_allowin), 128'd0);
        next_cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        check_vec("sw/bus", 128'(ms_to_ws_bus),
                  128'(mk_ms(1'b0, 1'b0, 1'b0, 4'h0, 5'd2, 32'h0000_0500, 32'hBFC0_0310)));
        check_vec("sw/valid", 128'(ms_to_ws_valid), 128'd1);
        next_cyc();
        data_sram_data_ok = 1'b0;

        // Excepting entry with a request still waits for its response.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b1, 1'b0, 1'b0, 1'b1, LW, 1'b1, 5'd5, 32'h0000_0603,
                               32'hBFC0_0400);
        es_mem_req     = 1'b1;
        next_cyc();
        es_to_ms_valid = 1'b0;
        es_mem_req     = 1'b0;
        @(negedge clk);
        check_vec("exc/exc_eret", 128'(ms_exc_eret), 128'd1);
        check_vec("exc/wait_valid", 128'(ms_to_ws_valid), 128'd0);
        next_cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0;
        @(negedge clk);
        check_vec("exc/valid", 128'(ms_to_ws_valid), 128'd1);
        check_vec("exc/bus", 128'(ms_to_ws_bus),
                  128'(mk_ms(1'b1, 1'b0, 1'b0, 4'hF, 5'd5, 32'h0, 32'hBFC0_0400)));
        next_cyc();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check_vec("exc/cleared", 128'(ms_exc_eret), 128'd0);

        // Flush a waiting load, then flush alongside a new request accept: two owed responses.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b0, 1'b0, 1'b0, 1'b1, LW, 1'b1, 5'd6, 32'h0000_0700,
                               32'hBFC0_0500);
        es_mem_req     = 1'b1;
        next_cyc();
        es_to_ms_valid = 1'b0;
        es_mem_req     = 1'b0;
        flush          = 1'b1;
        @(negedge clk);
        check_vec("cancel/allowin_waiting", 128'(ms_allowin), 128'd0);
        next_cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1'b0, 1'b0, 1'b0, 1'b1, LW, 1'b1, 5'd6, 32'h0000_0704,
                               32'hBFC0_0508);
        es_mem_req     = 1'b1;
        @(negedge clk);
        check_vec("cancel/cnt1", 128'(dut.cancel_cnt), 128'd1);
        check_vec("cancel/allowin_empty", 128'(ms_allowin), 128'd1);
        next_cyc();
        flush          = 1'b0;
        es_to_ms_bus   = mk_es(1'b0, 1'b0, 1'b0, 1'b1, LW, 1'b1, 5'd8, 32'h0000_0800,
                               32'hBFC0_0600);
        @(negedge clk);
        check_vec("cancel/cnt2", 128'(dut.cancel_cnt), 128'd2);
        check_vec("cancel/empty", 128'(ms_to_ws_valid), 128'd0);
        next_cyc();
        es_to_ms_valid = 1'b0;
        es_mem_req     = 1'b0;
        for (int r = 0; r < 2; r++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = (r == 0) ? 32'h1111_1111 : 32'h2222_2222;
            @(negedge clk);
            check_vec($sformatf("cancel/drop%0d", r), 128'(ms_to_ws_valid), 128'd0);
            next_cyc();
        end
        data_sram_rdata = 32'h3333_3333;
        @(negedge clk);
        check_vec("cancel/third_valid", 128'(ms_to_ws_valid), 128'd1);
        check_vec("cancel/third_bus", 128'(ms_to_ws_bus),
                  128'(mk_ms(1'b0, 1'b0, 1'b0, 4'hF, 5'd8, 32'h3333_3333, 32'hBFC0_0600)));
        next_cyc();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check_vec("cancel/cnt0", 128'(dut.cancel_cnt), 128'd0);
        check_vec("cancel/retired", 128'(ms_to_ws_valid), 128'd0);
        next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
